// File: rtl/divider_arbiter_if.sv
// Requester-side bus of divider_arbiter: request levels, packed operands,
// and the one-hot acknowledge with its result.
interface divider_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] op1_bus;
  logic [NUM_REQ*DATA_WIDTH-1:0] op2_bus;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         res_data;
  logic                          div_by_zero;

  modport master (
    output req, op1_bus, op2_bus,
    input  ack, res_data, div_by_zero
  );

  modport slave (
    input  req, op1_bus, op2_bus,
    output ack, res_data, div_by_zero
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sequencer sharing one multi-cycle divider among NUM_REQ clients;
// zero divisors are answered locally with an all-ones result.
module divider_arbiter #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  divider_arbiter_if.slave      bus,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] div_op1,
  output logic [DATA_WIDTH-1:0] div_op2,
  output logic                  div_start,
  input  logic [DATA_WIDTH-1:0] div_result,
  input  logic                  div_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] sel_op1;
  logic [DATA_WIDTH-1:0] sel_op2;
  logic [DATA_WIDTH-1:0] res_reg;
  logic                  dbz_reg;
  logic [NUM_REQ-1:0]    ack_vec;
  logic                  wait_armed;
  logic                  done_take;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Descending scan so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    sel_idx = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (bus.req[wrap_add(rr_ptr, NUM_REQ - 1 - k)]) begin
        sel_idx = wrap_add(rr_ptr, NUM_REQ - 1 - k);
      end
    end
  end

  assign sel_op1 = bus.op1_bus[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_op2 = bus.op2_bus[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];

  // A done seen in the first WAIT cycle may be left over from the previous operation.
  assign done_take = (state == WAIT) && wait_armed && div_done;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = (sel_op2 == '0) ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_take) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    div_start = 1'b0;
    ack_vec   = '0;
    case (state)
      ISSUE: begin
        busy      = 1'b1;
        div_start = 1'b1;
      end
      WAIT:  busy = 1'b1;
      RESP: begin
        busy               = 1'b1;
        ack_vec[grant_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant capture, result load and round-robin pointer update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr     <= '0;
      grant_idx  <= '0;
      div_op1    <= '0;
      div_op2    <= '0;
      res_reg    <= '0;
      dbz_reg    <= 1'b0;
      wait_armed <= 1'b0;
    end else begin
      wait_armed <= (state == WAIT);
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_idx <= sel_idx;
            div_op1   <= sel_op1;
            div_op2   <= sel_op2;
            if (sel_op2 == '0) begin
              res_reg <= '1;
              dbz_reg <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (done_take) begin
            res_reg <= div_result;
            dbz_reg <= 1'b0;
          end
        end
        RESP:    rr_ptr <= wrap_add(grant_idx, 1);
        default: ;
      endcase
    end
  end

  assign bus.ack         = ack_vec;
  assign bus.res_data    = res_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin arbiter and sequencer sharing one `divider` instance among `NUM_REQ` requesters (e.g. ALU divide path and a second execution client) in the multi-cycle processor. Grants one requester at a time, latches its operands, issues the single-cycle `start` to the divider, waits for `done`, and returns the result with a one-cycle acknowledge. Divide-by-zero requests are answered locally without occupying the divider.

## Interface
- `DATA_WIDTH`, 6, operand/result width; must match the shared divider.
- `NUM_REQ`, 2, number of requesters (2..8).
- `CLK`  in  1  clock; all logic rising-edge.
- `RST`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-requester request level.
- `op1_bus`  in  NUM_REQ*DATA_WIDTH  dividends; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `op2_bus`  in  NUM_REQ*DATA_WIDTH  divisors, same packing.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse to granted requester.
- `res_data`  out  DATA_WIDTH  result; valid only in the `ack` cycle.
- `div_by_zero`  out  1  high with `ack` when granted divisor was 0.
- `busy`  out  1  high in every state except IDLE.
- `div_op1`, `div_op2`  out  DATA_WIDTH  latched operands to divider `Operand1`/`Operand2`.
- `div_start`  out  1  to divider `start`.
- `div_result`  in  DATA_WIDTH  from divider `result`.
- `div_done`  in  1  from divider `done`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `req` nonzero, select first asserted requester scanning from `rr_ptr` upward, wrapping modulo NUM_REQ. Latch index to `grant_idx`, latch its operands into `div_op1`/`div_op2`. If latched divisor == 0 -> RESP with `res_data` = all ones, `div_by_zero` = 1; else -> ISSUE.
- ISSUE: `div_start` = 1 for exactly this cycle -> WAIT.
- WAIT: first WAIT cycle ignores `div_done` (stale done from previous operation). From the second WAIT cycle, `div_done` = 1 latches `div_result` into `res_data` -> RESP. No timeout.
- RESP: `ack[grant_idx]` = 1 for this cycle only; `rr_ptr` <= (grant_idx+1) mod NUM_REQ -> IDLE.
- Operands held stable on `div_op1`/`div_op2` from grant through RESP; requester operand changes after grant ignored.
- Requester dropping `req` after grant: operation still completes and `ack` still issued.
- `req` still high in IDLE after its `ack` = new request, re-arbitrated normally (round-robin prevents starvation).
- Divide-by-zero path also advances `rr_ptr`.
- `res_data`, `div_by_zero` hold their values until next RESP load; only meaningful with `ack`.
- `RST` high in any state: next edge -> IDLE, abandons in-flight op without `ack`; divider is assumed reset by the same `RST`.

## Timing
- Reset values: state IDLE, `ack` 0, `res_data` 0, `div_by_zero` 0, `busy` 0, `div_start` 0, `div_op1`/`div_op2` 0, `rr_ptr` 0.
- All outputs registered or decoded from state only; no combinational path from `req` to any output.
- Request sampled at edge k: ISSUE (`div_start`) in cycle k+1, WAIT from k+2; `div_done` sampled high at edge d (d >= k+3) -> `ack` in cycle d..d+1. Overhead = 3 cycles beyond divider latency.
- Divide-by-zero: request sampled at edge k -> `ack` in cycle k+1 (one-cycle latency).
- Back-to-back: minimum one IDLE cycle between `ack` and next `div_start`.
- `busy` high from cycle after grant through RESP inclusive.

## Test plan
- Reset: hold `RST` 2 cycles mid-WAIT -> all outputs zero next cycle, no `ack`, state IDLE.
- Single request: req[0], op1=45, op2=7 -> one `div_start` pulse, `ack`=2'b01 with `res_data`=6, `div_by_zero`=0.
- Divide-by-zero: req[1], op1=13, op2=0 -> `ack`=2'b10 one cycle after sampling, `res_data`=63, `div_by_zero`=1, `div_start` never asserted.
- Round-robin: req=2'b11 held continuously, ops (20/4) and (30/5) -> grants alternate 0,1,0,1; results 5 and 6; neither starved.
- Operand stability: after grant to req 0 (50/5), change op1_bus/op2_bus to 1/1 and drop req -> `div_op1`/`div_op2` stay 50/5, `ack` still issued, `res_data`=10.
- Stale done: divider `div_done` held high from previous op into first WAIT cycle -> ignored; `ack` only after fresh `div_done`.
